// File: rtl/shared_bank_reallocator.sv
`default_nettype none
// ============================================================================
// Module      : shared_bank_reallocator
// Description : Per-bank owner arbiter for shared input-VC memory banks.
//               Watches per-port congestion (all private VCs allocated for
//               a sustained period) and hands the bank's shared VCs to a
//               congested port picked round-robin, after draining the bank.
//               A drain that does not complete in time is aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_bank_reallocator #(
    parameter int NUM_PORTS         = 5,
    parameter int NUM_VCS_PER_BANK  = 1,
    parameter int COUNTER_WIDTH     = 4,
    parameter int CONGEST_THRESHOLD = 15,
    parameter int TIMEOUT_WIDTH     = 6,
    parameter int RESET_OWNER       = 0,
    parameter int PORT_IDX_WIDTH    = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS*NUM_VCS_PER_BANK-1:0]  private_ivc_allocated,
    input  logic [NUM_PORTS*NUM_VCS_PER_BANK-1:0]  shared_ivc_allocated,
    input  logic [NUM_VCS_PER_BANK-1:0]            shared_ivc_empty,
    output logic                                   ready_for_allocation,
    output logic [NUM_PORTS-1:0]                   bank_grant,
    output logic [PORT_IDX_WIDTH-1:0]              owner_id,
    output logic                                   reassign,
    output logic                                   drain_abort
);

    localparam logic [COUNTER_WIDTH-1:0]  C_CNT_MAX      = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0]  C_THRESH       = COUNTER_WIDTH'(CONGEST_THRESHOLD);
    // The registered timeout starts at 0 in the first drain cycle, so the
    // last permitted drain cycle (number 2^TIMEOUT_WIDTH-1) sees this value.
    localparam logic [TIMEOUT_WIDTH-1:0]  C_TIMEOUT_LAST = TIMEOUT_WIDTH'((1 << TIMEOUT_WIDTH) - 2);
    localparam logic [PORT_IDX_WIDTH-1:0] C_RESET_OWNER  = PORT_IDX_WIDTH'(RESET_OWNER);
    localparam logic [PORT_IDX_WIDTH-1:0] C_LAST_PORT    = PORT_IDX_WIDTH'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0]      C_RESET_GRANT  = NUM_PORTS'(1) << RESET_OWNER;

    typedef enum logic [1:0] {
        S_ENABLE = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t                    r_state_q,    w_state_d;
    logic [PORT_IDX_WIDTH-1:0] r_winner_q,   w_winner_d;
    logic [TIMEOUT_WIDTH-1:0]  r_timeout_q,  w_timeout_d;
    logic [NUM_PORTS-1:0]      r_grant_q,    w_grant_d;
    logic [PORT_IDX_WIDTH-1:0] r_owner_q,    w_owner_d;
    logic [PORT_IDX_WIDTH-1:0] r_rr_q,       w_rr_d;
    logic                      r_reassign_q, w_reassign_d;
    logic                      r_abort_q,    w_abort_d;
    logic                      w_ready;

    logic [NUM_PORTS-1:0]      w_full;
    logic [NUM_PORTS-1:0]      w_congested;
    logic [NUM_PORTS-1:0]      w_cand;
    logic [PORT_IDX_WIDTH-1:0] w_pick;
    logic                      w_found;
    logic                      w_drained;
    logic                      w_timeout_hit;

    // Per-port saturating congestion counters; they only accumulate while
    // the bank is open for allocation and restart from zero otherwise.
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [COUNTER_WIDTH-1:0] r_cnt_q;

            assign w_full[p]      = &private_ivc_allocated[p*NUM_VCS_PER_BANK +: NUM_VCS_PER_BANK];
            assign w_congested[p] = (r_cnt_q >= C_THRESH);

            // Count consecutive full cycles, saturating at the counter maximum.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt_q <= '0;
                end else if ((r_state_q == S_ENABLE) && w_full[p]) begin
                    if (r_cnt_q != C_CNT_MAX) begin
                        r_cnt_q <= r_cnt_q + COUNTER_WIDTH'(1);
                    end
                end else begin
                    r_cnt_q <= '0;
                end
            end
        end
    endgenerate

    // The current owner never competes for its own bank.
    assign w_cand        = w_congested & ~r_grant_q;
    assign w_drained     = ~(|shared_ivc_allocated) & (&shared_ivc_empty);
    assign w_timeout_hit = (r_timeout_q == C_TIMEOUT_LAST);

    // Round-robin search: first candidate at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_pick  = r_rr_q;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(r_rr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!w_found && w_cand[idx]) begin
                w_found = 1'b1;
                w_pick  = PORT_IDX_WIDTH'(idx);
            end
        end
    end

    // Owner FSM next-state and output decode.
    always_comb begin
        w_state_d    = r_state_q;
        w_winner_d   = r_winner_q;
        w_timeout_d  = r_timeout_q;
        w_grant_d    = r_grant_q;
        w_owner_d    = r_owner_q;
        w_rr_d       = r_rr_q;
        w_reassign_d = 1'b0;
        w_abort_d    = 1'b0;
        w_ready      = 1'b0;
        case (r_state_q)
            S_ENABLE: begin
                w_ready = 1'b1;
                if (w_found) begin
                    w_winner_d  = w_pick;
                    w_timeout_d = '0;
                    w_state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_timeout_d = r_timeout_q + TIMEOUT_WIDTH'(1);
                // A completed drain wins over a simultaneous timeout.
                if (w_drained) begin
                    w_state_d = S_SWITCH;
                end else if (w_timeout_hit) begin
                    w_state_d = S_ENABLE;
                    w_abort_d = 1'b1;
                end
            end
            S_SWITCH: begin
                w_state_d    = S_ENABLE;
                w_grant_d    = NUM_PORTS'(1) << r_winner_q;
                w_owner_d    = r_winner_q;
                w_rr_d       = (r_winner_q == C_LAST_PORT) ? '0 : r_winner_q + PORT_IDX_WIDTH'(1);
                w_reassign_d = 1'b1;
            end
            default: begin
                w_state_d = S_ENABLE;
            end
        endcase
    end

    // FSM state, ownership and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q    <= S_ENABLE;
            r_winner_q   <= C_RESET_OWNER;
            r_timeout_q  <= '0;
            r_grant_q    <= C_RESET_GRANT;
            r_owner_q    <= C_RESET_OWNER;
            r_rr_q       <= '0;
            r_reassign_q <= 1'b0;
            r_abort_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_winner_q   <= w_winner_d;
            r_timeout_q  <= w_timeout_d;
            r_grant_q    <= w_grant_d;
            r_owner_q    <= w_owner_d;
            r_rr_q       <= w_rr_d;
            r_reassign_q <= w_reassign_d;
            r_abort_q    <= w_abort_d;
        end
    end

    assign ready_for_allocation = w_ready;
    assign bank_grant           = r_grant_q;
    assign owner_id             = r_owner_q;
    assign reassign             = r_reassign_q;
    assign drain_abort          = r_abort_q;

endmodule
`default_nettype wire
